if_layer_refrac_controller: RTL and testbench
=============================================

# if_layer_refrac_controller

Per-layer spike controller for integrate-and-fire neuron arrays: registers incoming spikes, enforces a per-neuron refractory period, drives each neuron's membrane reset, and optionally applies winner-take-all lateral inhibition. It sits between a layer of IF neurons and the downstream layer or spike monitor. It supersedes the single-cycle spike-to-reset controller by adding refractory counting, a timestep enable, an inhibition mode and a layer spike counter.

## Interface
- NUM_NEURONS, 4, neurons in the layer (≥1)
- REFRAC, 5, refractory length in enabled cycles (0 = reset pulse only, no blocking)
- INHIBIT_EN, 0, 1 = winner-take-all lateral inhibition
- CNT_W, 8, width of layer spike counter
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, synchronous, active-low (rst==0 at a rising edge resets)
- enable  in  1  timestep advance; 0 freezes all state
- spike_in  in  NUM_NEURONS  raw spikes from neurons, sampled each enabled edge
- clear_cnt  in  1  synchronous clear of spike_total
- spike_out  out  NUM_NEURONS  accepted spikes, registered, one-cycle pulses
- neuron_rst  out  NUM_NEURONS  membrane reset/hold per neuron, registered
- refrac_active  out  NUM_NEURONS  1 while neuron's refractory counter is nonzero
- spike_total  out  CNT_W  saturating count of accepted spikes since last clear

## Operation
- Per neuron: counter cnt[i], width $clog2(REFRAC+1) (min 1); states READY (cnt==0) / REFRACTORY (cnt>0).
- valid[i] = spike_in[i] & (cnt[i]==0). Spikes on REFRACTORY neurons are dropped, not queued.
- INHIBIT_EN=0: accept[i] = valid[i].
- INHIBIT_EN=1: accept = lowest-index set bit of valid only; when any accept, every other neuron (READY or not) reloads cnt to REFRAC (inhibited).
- Accepted neuron: cnt ← REFRAC; spike_out[i] ← 1.
- Otherwise cnt>0 decrements by 1 per enabled cycle.
- neuron_rst[i] ← accept[i] | inhibited[i] | (cnt_next[i] != 0).
- refrac_active[i] = (cnt[i] != 0), direct from state.
- spike_total ← clear_cnt ? popcount(accept) : sat(spike_total + popcount(accept)); saturates at 2^CNT_W−1, never wraps.
- enable=0: cnt, neuron_rst, spike_total hold; spike_out ← 0; spike_in ignored. clear_cnt still honoured.
- Reset: cnt=0, spike_out=0, neuron_rst=all ones, spike_total=0. Reset mid-refractory aborts counting; first enabled cycle after release accepts spikes normally.

## Timing
- Spike sampled at enabled edge k → spike_out, neuron_rst high after edge k (1-cycle latency).
- REFRAC=R>0: neuron_rst high for exactly R enabled cycles after the spike; spikes on enabled cycles k+1..k+R dropped; spike at k+R+1 accepted.
- REFRAC=0: neuron_rst is a one-cycle pulse per spike; back-to-back spikes all accepted.
- Disabled cycles stretch the refractory window; they do not count.
- Inhibition reload on an already-refractory neuron restarts its window at R.

## Structure
- Package snn_layer_pkg: lowest-set-bit function, popcount function, saturating-add function, refractory-width helper.
- Sub-module if_refrac_counter: one per neuron via generate; inputs load, enable; outputs cnt_zero, cnt_next_nonzero.
- Top holds inhibition arbitration, output registers and spike_total.

## Test plan
- Reset: rst=0 two cycles → neuron_rst=4'b1111, spike_out=0, spike_total=0; release, no spikes, enable=1 → neuron_rst=0 next cycle.
- Refractory, R=5, N=4, INHIBIT_EN=0: spike_in[1] held high → spike_out[1] pulses on cycles 0, 6, 12; neuron_rst[1] high 5 cycles each; spike_total=3.
- Enable gating: spike neuron 0, then enable low 3 cycles mid-window → window ends 3 cycles later; spike_out=0 while disabled.
- Inhibition, INHIBIT_EN=1, R=3: spike_in=4'b1010 → spike_out=4'b0010, neuron_rst=4'b1111 for 3 cycles, spike_total=1.
- Saturation/clear, CNT_W=3, R=0: all 4 neurons spike 2 cycles → spike_total=7; clear_cnt with spike_in=4'b0011 → 2.
- REFRAC=0, INHIBIT_EN=0: spike_in toggles 4'b0101 every cycle → spike_out mirrors delayed by 1, neuron_rst identical pulses.

Source files
------------

// File: rtl/snn_layer_pkg.sv
// Shared helpers for the spiking-layer controllers.
//   refrac_width   : counter width able to hold a refractory length (min 1 bit)
//   lowest_set_bit : isolates the lowest-index set bit (one-hot or zero)
//   popcount       : number of set bits
//   sat_add        : unsigned add clamped to 2^w - 1
package snn_layer_pkg;

    localparam int unsigned MAX_N = 64;
    localparam int unsigned MAX_W = 32;

    function automatic int unsigned refrac_width(input int unsigned refrac);
        int unsigned w;
        w = $clog2(refrac + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic logic [MAX_N-1:0] lowest_set_bit(input logic [MAX_N-1:0] v);
        return v & (~v + MAX_N'(1));
    endfunction

    function automatic int unsigned popcount(input logic [MAX_N-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] a,
                                                 input logic [MAX_W-1:0] b,
                                                 input int unsigned      w);
        logic [63:0] sum;
        logic [63:0] max_v;
        max_v = (64'd1 << w) - 64'd1;
        sum   = 64'(a) + 64'(b);
        return (sum > max_v) ? max_v[MAX_W-1:0] : sum[MAX_W-1:0];
    endfunction

endpackage

// File: rtl/if_refrac_counter.sv
// Per-neuron refractory down-counter.
//   clk, rst         : clock, synchronous active-low reset
//   enable           : timestep advance; 0 holds the count
//   load             : reload the count to REFRAC (accepted or inhibited)
//   cnt_zero         : neuron is READY (count is zero)
//   cnt_next_nonzero : count after this edge will be nonzero
module if_refrac_counter
    import snn_layer_pkg::*;
#(
    parameter int unsigned REFRAC = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic load,
    output logic cnt_zero,
    output logic cnt_next_nonzero
);

    localparam int unsigned   CW     = refrac_width(REFRAC);
    localparam logic [CW-1:0] RELOAD = CW'(REFRAC);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (enable) begin
            if (load) begin
                cnt_d = RELOAD;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_zero         = (cnt_q == '0);
    assign cnt_next_nonzero = (cnt_d != '0);

endmodule

// File: rtl/if_layer_refrac_controller.sv
// Layer spike controller for integrate-and-fire neurons: accepts spikes from
// READY neurons, runs per-neuron refractory windows, drives membrane resets,
// optionally applies winner-take-all inhibition, and counts accepted spikes.
//   clk, rst      : clock, synchronous active-low reset
//   enable        : timestep advance; 0 freezes state and blanks spike_out
//   spike_in      : raw neuron spikes
//   clear_cnt     : synchronous clear of spike_total (honoured when disabled)
//   spike_out     : accepted spikes, one-cycle registered pulses
//   neuron_rst    : registered membrane reset/hold per neuron
//   refrac_active : neuron refractory counter is nonzero
//   spike_total   : saturating accepted-spike count
module if_layer_refrac_controller
    import snn_layer_pkg::*;
#(
    parameter int unsigned NUM_NEURONS = 4,
    parameter int unsigned REFRAC      = 5,
    parameter bit          INHIBIT_EN  = 1'b0,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [NUM_NEURONS-1:0] spike_in,
    input  logic                   clear_cnt,
    output logic [NUM_NEURONS-1:0] spike_out,
    output logic [NUM_NEURONS-1:0] neuron_rst,
    output logic [NUM_NEURONS-1:0] refrac_active,
    output logic [CNT_W-1:0]       spike_total
);

    logic [NUM_NEURONS-1:0] cnt_zero;
    logic [NUM_NEURONS-1:0] cnt_next_nz;
    logic [NUM_NEURONS-1:0] valid;
    logic [NUM_NEURONS-1:0] accept;
    logic [NUM_NEURONS-1:0] inhibited;
    logic [NUM_NEURONS-1:0] load;
    logic [MAX_W-1:0]       pop;

    logic [NUM_NEURONS-1:0] spike_out_q,   spike_out_d;
    logic [NUM_NEURONS-1:0] neuron_rst_q,  neuron_rst_d;
    logic [CNT_W-1:0]       spike_total_q, spike_total_d;

    for (genvar i = 0; i < NUM_NEURONS; i++) begin : g_cnt
        if_refrac_counter #(
            .REFRAC(REFRAC)
        ) u_cnt (
            .clk              (clk),
            .rst              (rst),
            .enable           (enable),
            .load             (load[i]),
            .cnt_zero         (cnt_zero[i]),
            .cnt_next_nonzero (cnt_next_nz[i])
        );
    end

    // Arbitration: under inhibition only the lowest-index READY spiker wins and
    // every other neuron, refractory or not, restarts its window.
    always_comb begin
        valid     = spike_in & cnt_zero;
        accept    = valid;
        inhibited = '0;
        if (INHIBIT_EN) begin
            accept = NUM_NEURONS'(lowest_set_bit(MAX_N'(valid)));
            if (|accept) begin
                inhibited = ~accept;
            end
        end
        load = accept | inhibited;
        pop  = enable ? MAX_W'(popcount(MAX_N'(accept))) : '0;
    end

    always_comb begin
        spike_out_d  = '0;
        neuron_rst_d = neuron_rst_q;
        if (enable) begin
            spike_out_d  = accept;
            neuron_rst_d = accept | inhibited | cnt_next_nz;
        end
        if (clear_cnt) begin
            spike_total_d = CNT_W'(pop);
        end else begin
            spike_total_d = CNT_W'(sat_add(MAX_W'(spike_total_q), pop, CNT_W));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            spike_out_q   <= '0;
            neuron_rst_q  <= '1;
            spike_total_q <= '0;
        end else begin
            spike_out_q   <= spike_out_d;
            neuron_rst_q  <= neuron_rst_d;
            spike_total_q <= spike_total_d;
        end
    end

    assign spike_out     = spike_out_q;
    assign neuron_rst    = neuron_rst_q;
    assign refrac_active = ~cnt_zero;
    assign spike_total   = spike_total_q;

endmodule

// File: tb/tb_if_layer_refrac_controller.sv
// Directed bench for if_layer_refrac_controller using three configurations:
//   dut_a : R=5, no inhibition, 8-bit counter
//   dut_b : R=3, winner-take-all, 8-bit counter
//   dut_c : R=0, no inhibition, 3-bit counter
module tb_if_layer_refrac_controller;

    logic clk;
    logic rst;

    logic       en_a, clr_a, en_b, clr_b, en_c, clr_c;
    logic [3:0] spk_a, spk_b, spk_c;
    logic [3:0] so_a, nr_a, ra_a;
    logic [3:0] so_b, nr_b, ra_b;
    logic [3:0] so_c, nr_c, ra_c;
    logic [7:0] tot_a, tot_b;
    logic [2:0] tot_c;

    int checks;
    int errors;

    if_layer_refrac_controller #(
        .NUM_NEURONS(4), .REFRAC(5), .INHIBIT_EN(1'b0), .CNT_W(8)
    ) dut_a (
        .clk(clk), .rst(rst), .enable(en_a), .spike_in(spk_a), .clear_cnt(clr_a),
        .spike_out(so_a), .neuron_rst(nr_a), .refrac_active(ra_a), .spike_total(tot_a)
    );

    if_layer_refrac_controller #(
        .NUM_NEURONS(4), .REFRAC(3), .INHIBIT_EN(1'b1), .CNT_W(8)
    ) dut_b (
        .clk(clk), .rst(rst), .enable(en_b), .spike_in(spk_b), .clear_cnt(clr_b),
        .spike_out(so_b), .neuron_rst(nr_b), .refrac_active(ra_b), .spike_total(tot_b)
    );

    if_layer_refrac_controller #(
        .NUM_NEURONS(4), .REFRAC(0), .INHIBIT_EN(1'b0), .CNT_W(3)
    ) dut_c (
        .clk(clk), .rst(rst), .enable(en_c), .spike_in(spk_c), .clear_cnt(clr_c),
        .spike_out(so_c), .neuron_rst(nr_c), .refrac_active(ra_c), .spike_total(tot_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tick();
        tick();
        checks++; if (nr_a !== 4'b1111) begin errors++; $display("FAIL reset_nr_a got %b exp 1111", nr_a); end
        checks++; if (so_a !== 4'b0000) begin errors++; $display("FAIL reset_so_a got %b exp 0000", so_a); end
        checks++; if (tot_a !== 8'd0) begin errors++; $display("FAIL reset_tot_a got %0d exp 0", tot_a); end
        checks++; if (ra_a !== 4'b0000) begin errors++; $display("FAIL reset_ra_a got %b exp 0000", ra_a); end
        checks++; if (nr_b !== 4'b1111) begin errors++; $display("FAIL reset_nr_b got %b exp 1111", nr_b); end
        rst = 1'b1;
        tick();
        checks++; if (nr_a !== 4'b0000) begin errors++; $display("FAIL release_nr_a got %b exp 0000", nr_a); end
        checks++; if (nr_b !== 4'b0000) begin errors++; $display("FAIL release_nr_b got %b exp 0000", nr_b); end
    endtask

    task automatic test_refractory;
        logic [3:0] exp_so, exp_nr;
        spk_a = 4'b0010;
        for (int c = 0; c <= 12; c++) begin
            tick();
            exp_so = (c % 6 == 0) ? 4'b0010 : 4'b0000;
            exp_nr = (c % 6 < 5)  ? 4'b0010 : 4'b0000;
            checks++; if (so_a !== exp_so) begin errors++; $display("FAIL refrac_so c=%0d got %b exp %b", c, so_a, exp_so); end
            checks++; if (nr_a !== exp_nr) begin errors++; $display("FAIL refrac_nr c=%0d got %b exp %b", c, nr_a, exp_nr); end
            checks++; if (ra_a !== exp_nr) begin errors++; $display("FAIL refrac_ra c=%0d got %b exp %b", c, ra_a, exp_nr); end
        end
        checks++; if (tot_a !== 8'd3) begin errors++; $display("FAIL refrac_total got %0d exp 3", tot_a); end
        spk_a = 4'b0000;
        repeat (5) tick();
        checks++; if (nr_a !== 4'b0000) begin errors++; $display("FAIL refrac_end_nr got %b exp 0000", nr_a); end
        checks++; if (ra_a !== 4'b0000) begin errors++; $display("FAIL refrac_end_ra got %b exp 0000", ra_a); end
    endtask

    task automatic test_enable_gating;
        spk_a = 4'b0001;
        tick();
        checks++; if (so_a !== 4'b0001) begin errors++; $display("FAIL gate_so got %b exp 0001", so_a); end
        checks++; if (tot_a !== 8'd4) begin errors++; $display("FAIL gate_tot got %0d exp 4", tot_a); end
        spk_a = 4'b0000;
        tick();
        tick();
        en_a  = 1'b0;
        spk_a = 4'b1111;
        for (int d = 0; d < 3; d++) begin
            tick();
            checks++; if (so_a !== 4'b0000) begin errors++; $display("FAIL gate_dis_so d=%0d got %b exp 0000", d, so_a); end
            checks++; if (nr_a !== 4'b0001) begin errors++; $display("FAIL gate_dis_nr d=%0d got %b exp 0001", d, nr_a); end
            checks++; if (ra_a !== 4'b0001) begin errors++; $display("FAIL gate_dis_ra d=%0d got %b exp 0001", d, ra_a); end
        end
        checks++; if (tot_a !== 8'd4) begin errors++; $display("FAIL gate_dis_tot got %0d exp 4", tot_a); end
        en_a  = 1'b1;
        spk_a = 4'b0000;
        tick();
        checks++; if (nr_a !== 4'b0001) begin errors++; $display("FAIL gate_resume1_nr got %b exp 0001", nr_a); end
        tick();
        checks++; if (nr_a !== 4'b0001) begin errors++; $display("FAIL gate_resume2_nr got %b exp 0001", nr_a); end
        tick();
        checks++; if (nr_a !== 4'b0000) begin errors++; $display("FAIL gate_resume3_nr got %b exp 0000", nr_a); end
        checks++; if (ra_a !== 4'b0000) begin errors++; $display("FAIL gate_resume3_ra got %b exp 0000", ra_a); end
        en_a  = 1'b0;
        clr_a = 1'b1;
        tick();
        checks++; if (tot_a !== 8'd0) begin errors++; $display("FAIL gate_clear_dis got %0d exp 0", tot_a); end
        clr_a = 1'b0;
        en_a  = 1'b1;
    endtask

    task automatic test_inhibit;
        spk_b = 4'b1010;
        tick();
        checks++; if (so_b !== 4'b0010) begin errors++; $display("FAIL inh_so got %b exp 0010", so_b); end
        checks++; if (nr_b !== 4'b1111) begin errors++; $display("FAIL inh_nr0 got %b exp 1111", nr_b); end
        checks++; if (ra_b !== 4'b1111) begin errors++; $display("FAIL inh_ra got %b exp 1111", ra_b); end
        checks++; if (tot_b !== 8'd1) begin errors++; $display("FAIL inh_tot got %0d exp 1", tot_b); end
        spk_b = 4'b0000;
        tick();
        checks++; if (nr_b !== 4'b1111) begin errors++; $display("FAIL inh_nr1 got %b exp 1111", nr_b); end
        tick();
        checks++; if (nr_b !== 4'b1111) begin errors++; $display("FAIL inh_nr2 got %b exp 1111", nr_b); end
        tick();
        checks++; if (nr_b !== 4'b0000) begin errors++; $display("FAIL inh_nr3 got %b exp 0000", nr_b); end
        spk_b = 4'b1000;
        tick();
        checks++; if (so_b !== 4'b1000) begin errors++; $display("FAIL inh2_so got %b exp 1000", so_b); end
        checks++; if (nr_b !== 4'b1111) begin errors++; $display("FAIL inh2_nr got %b exp 1111", nr_b); end
        spk_b = 4'b0001;
        tick();
        checks++; if (so_b !== 4'b0000) begin errors++; $display("FAIL inh_drop_so got %b exp 0000", so_b); end
        checks++; if (tot_b !== 8'd2) begin errors++; $display("FAIL inh_drop_tot got %0d exp 2", tot_b); end
        spk_b = 4'b0000;
        tick();
        tick();
        checks++; if (nr_b !== 4'b0000) begin errors++; $display("FAIL inh_end_nr got %b exp 0000", nr_b); end
    endtask

    task automatic test_saturation;
        spk_c = 4'b1111;
        tick();
        checks++; if (so_c !== 4'b1111) begin errors++; $display("FAIL sat_so got %b exp 1111", so_c); end
        checks++; if (nr_c !== 4'b1111) begin errors++; $display("FAIL sat_nr got %b exp 1111", nr_c); end
        checks++; if (tot_c !== 3'd4) begin errors++; $display("FAIL sat_tot1 got %0d exp 4", tot_c); end
        tick();
        checks++; if (tot_c !== 3'd7) begin errors++; $display("FAIL sat_tot2 got %0d exp 7", tot_c); end
        spk_c = 4'b0011;
        clr_c = 1'b1;
        tick();
        checks++; if (tot_c !== 3'd2) begin errors++; $display("FAIL sat_clear got %0d exp 2", tot_c); end
        checks++; if (so_c !== 4'b0011) begin errors++; $display("FAIL sat_clear_so got %b exp 0011", so_c); end
        clr_c = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [3:0] p;
        for (int i = 0; i < 6; i++) begin
            p = (i % 2 == 0) ? 4'b0101 : 4'b0000;
            spk_c = p;
            tick();
            checks++; if (so_c !== p) begin errors++; $display("FAIL b2b_so i=%0d got %b exp %b", i, so_c, p); end
            checks++; if (nr_c !== p) begin errors++; $display("FAIL b2b_nr i=%0d got %b exp %b", i, nr_c, p); end
            checks++; if (ra_c !== 4'b0000) begin errors++; $display("FAIL b2b_ra i=%0d got %b exp 0000", i, ra_c); end
        end
        checks++; if (tot_c !== 3'd7) begin errors++; $display("FAIL b2b_tot got %0d exp 7", tot_c); end
        spk_c = 4'b0000;
    endtask

    task automatic test_reset_mid;
        spk_a = 4'b0100;
        tick();
        checks++; if (so_a !== 4'b0100) begin errors++; $display("FAIL rmid_so got %b exp 0100", so_a); end
        checks++; if (tot_a !== 8'd1) begin errors++; $display("FAIL rmid_tot got %0d exp 1", tot_a); end
        rst = 1'b0;
        tick();
        checks++; if (nr_a !== 4'b1111) begin errors++; $display("FAIL rmid_rst_nr got %b exp 1111", nr_a); end
        checks++; if (so_a !== 4'b0000) begin errors++; $display("FAIL rmid_rst_so got %b exp 0000", so_a); end
        checks++; if (ra_a !== 4'b0000) begin errors++; $display("FAIL rmid_rst_ra got %b exp 0000", ra_a); end
        checks++; if (tot_a !== 8'd0) begin errors++; $display("FAIL rmid_rst_tot got %0d exp 0", tot_a); end
        rst = 1'b1;
        tick();
        checks++; if (so_a !== 4'b0100) begin errors++; $display("FAIL rmid_after_so got %b exp 0100", so_a); end
        checks++; if (nr_a !== 4'b0100) begin errors++; $display("FAIL rmid_after_nr got %b exp 0100", nr_a); end
        checks++; if (tot_a !== 8'd1) begin errors++; $display("FAIL rmid_after_tot got %0d exp 1", tot_a); end
        spk_a = 4'b0000;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst   = 1'b0;
        en_a  = 1'b1; en_b  = 1'b1; en_c  = 1'b1;
        clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
        spk_a = '0;   spk_b = '0;   spk_c = '0;

        test_reset();
        test_refractory();
        test_enable_gating();
        test_inhibit();
        test_saturation();
        test_back_to_back();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
